// File: rtl/ddr3_rd_bitslip.sv
// Read-data bitslip trainer for one DDR3 DQ lane: aligns each IDES4 against a
// known training burst by pulsing CALIB, then forwards registered read data.

module ddr3_rd_bitslip_bit #(
    parameter logic [3:0] PATTERN = 4'b1010
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] q,
    input  logic       clr,
    input  logic       beat,
    input  logic       win_end,
    input  logic       slip,
    output logic       bad_now,
    output logic       exhausted,
    output logic       calib,
    output logic       locked,
    output logic [1:0] slips
);
    logic bad;
    logic mis;

    assign mis       = beat && (q != PATTERN);
    // bad state as it stands including this beat; locked bits never count as bad
    assign bad_now   = !locked && (bad || mis);
    assign exhausted = bad_now && (slips == 2'd3);
    assign calib     = slip && bad && !locked;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bad    <= 1'b0;
            locked <= 1'b0;
            slips  <= 2'd0;
        end else if (clr) begin
            bad    <= 1'b0;
            locked <= 1'b0;
            slips  <= 2'd0;
        end else if (slip) begin
            if (calib) slips <= slips + 2'd1;
            bad <= 1'b0;
        end else if (beat) begin
            bad <= bad_now;
            if (win_end && !bad_now) locked <= 1'b1;
        end
    end
endmodule

module ddr3_rd_bitslip #(
    parameter int          WIDTH   = 8,
    parameter logic [3:0]  PATTERN = 4'b1010,
    parameter int          MATCHES = 4,
    parameter int          SETTLE  = 6
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start_i,
    input  logic                 valid_i,
    input  logic [4*WIDTH-1:0]   data_i,
    output logic [WIDTH-1:0]     calib_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 fail_o,
    output logic [WIDTH-1:0]     locked_o,
    output logic [2*WIDTH-1:0]   slips_o,
    output logic                 valid_o,
    output logic [4*WIDTH-1:0]   data_o
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_CHECK, ST_SLIP, ST_SETTLE, ST_DONE, ST_FAIL
    } state_t;

    state_t state, state_nxt;

    logic [3:0]                beat_cnt;
    logic [3:0]                settle_cnt;
    logic [WIDTH-1:0][3:0]     q_bit;
    logic [WIDTH-1:0][1:0]     slips_a;
    logic [WIDTH-1:0]          bad_now;
    logic [WIDTH-1:0]          exhausted;
    logic                      start_acc;
    logic                      beat;
    logic                      win_end;
    logic                      slip;
    logic                      all_lock;

    assign busy_o    = (state == ST_CHECK) || (state == ST_SLIP) || (state == ST_SETTLE);
    assign done_o    = (state == ST_DONE);
    assign fail_o    = (state == ST_FAIL);
    assign start_acc = start_i && !busy_o;
    assign beat      = (state == ST_CHECK) && valid_i;
    assign win_end   = beat && (beat_cnt == 4'(MATCHES - 1));
    assign slip      = (state == ST_SLIP);
    assign all_lock  = &(locked_o | ~bad_now);
    assign slips_o   = slips_a;

    for (genvar b = 0; b < WIDTH; b++) begin : gen_bit
        assign q_bit[b] = {data_i[3*WIDTH+b], data_i[2*WIDTH+b], data_i[WIDTH+b], data_i[b]};

        ddr3_rd_bitslip_bit #(.PATTERN(PATTERN)) u_bit (
            .clock     (clock),
            .reset_n   (reset_n),
            .q         (q_bit[b]),
            .clr       (start_acc),
            .beat      (beat),
            .win_end   (win_end),
            .slip      (slip),
            .bad_now   (bad_now[b]),
            .exhausted (exhausted[b]),
            .calib     (calib_o[b]),
            .locked    (locked_o[b]),
            .slips     (slips_a[b])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE, ST_FAIL: if (start_acc) state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (win_end) begin
                    if (all_lock)        state_nxt = ST_DONE;
                    else if (|exhausted) state_nxt = ST_FAIL;
                    else                 state_nxt = ST_SLIP;
                end
            end
            ST_SLIP:   state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == 4'(SETTLE - 1)) state_nxt = ST_CHECK;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt   <= 4'd0;
            settle_cnt <= 4'd0;
        end else begin
            if (start_acc || slip || win_end) beat_cnt <= 4'd0;
            else if (beat)                    beat_cnt <= beat_cnt + 4'd1;
            settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 4'd1 : 4'd0;
        end
    end

    // read datapath: plain one-cycle register, independent of training
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            valid_o <= valid_i;
            data_o  <= data_i;
        end
    end
endmodule

// File: tb/tb_ddr3_rd_bitslip.sv
// Bench for ddr3_rd_bitslip: IDES4 rotation model driven by CALIB, outcome
// predicted from how many rotations each bit needs to present the pattern.

module tb_ddr3_rd_bitslip;
    localparam int         W   = 2;
    localparam int         M   = 4;
    localparam int         S   = 6;
    localparam logic [3:0] PAT = 4'b1010;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b0;
    logic             start_i = 1'b0;
    logic             valid_i = 1'b0;
    logic [4*W-1:0]   data_i  = '0;
    logic [W-1:0]     calib_o;
    logic             busy_o, done_o, fail_o, valid_o;
    logic [W-1:0]     locked_o;
    logic [2*W-1:0]   slips_o;
    logic [4*W-1:0]   data_o;

    always #5 clock = ~clock;

    ddr3_rd_bitslip #(.WIDTH(W), .PATTERN(PAT), .MATCHES(M), .SETTLE(S)) dut (
        .clock(clock), .reset_n(reset_n), .start_i(start_i), .valid_i(valid_i),
        .data_i(data_i), .calib_o(calib_o), .busy_o(busy_o), .done_o(done_o),
        .fail_o(fail_o), .locked_o(locked_o), .slips_o(slips_o),
        .valid_o(valid_o), .data_o(data_o)
    );

    int         vec = 0;
    int         errs = 0;
    int         cyc = 0;
    int         pulses[W] = '{default: 0};
    int         last_p[W] = '{default: -1000};
    int         base[W]   = '{default: 0};
    int         rot0[W]   = '{default: 0};
    bit         never[W]  = '{default: 0};
    logic [3:0] cval[W]   = '{default: 4'h0};
    logic [W-1:0] prevcal = '0;
    logic       rst_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rotq(input logic [3:0] p, input int r);
        logic [7:0] d;
        d = {p, p} << (r % 4);
        return d[7:4];
    endfunction

    function automatic logic [3:0] cur_q(input int b);
        return never[b] ? cval[b] : rotq(PAT, rot0[b] + pulses[b] - base[b]);
    endfunction

    // CALIB pulses a bit must receive before it presents the pattern (4 = never)
    function automatic int needed(input int b);
        if (never[b]) return 4;
        for (int n = 0; n < 4; n++)
            if (rotq(PAT, rot0[b] + n) == PAT) return n;
        return 4;
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clock);
            cyc++;
            if (reset_n && rst_prev) begin
                chk("valid_o_delay", valid_o, valid_i);
                chk("data_o_delay", data_o, data_i);
            end
            rst_prev = reset_n;
            for (int b = 0; b < W; b++) begin
                if (calib_o[b]) begin
                    chk("calib_width", prevcal[b], 1'b0);
                    chk("calib_gap", (cyc - last_p[b]) >= (S + M), 1'b1);
                    chk("calib_on_locked", locked_o[b], 1'b0);
                    pulses[b]++;
                    last_p[b] = cyc;
                end
            end
            prevcal = calib_o;
        end
    endtask

    task automatic step(input bit v, input bit st, input bit zero_idle);
        #1;
        start_i = st;
        valid_i = v;
        for (int b = 0; b < W; b++) begin
            logic [3:0] q;
            q = cur_q(b);
            for (int k = 0; k < 4; k++)
                data_i[k*W+b] = v ? q[k] : (zero_idle ? 1'b0 : 1'($urandom));
        end
        @(negedge clock);
    endtask

    task automatic start_train();
        for (int b = 0; b < W; b++) base[b] = pulses[b];
        step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic run_until(input int pct, input bit rand_start);
        int n = 0;
        while (!(done_o || fail_o) && n < 400) begin
            step($urandom_range(99) < pct, rand_start && ($urandom_range(15) == 0), 1'b0);
            n++;
        end
        chk("train_timeout", done_o || fail_o, 1'b1);
    endtask

    task automatic check_model();
        int mx = 0;
        int n;
        logic [2*W-1:0] es;
        logic [W-1:0]   el;
        for (int b = 0; b < W; b++) begin
            n = needed(b);
            if (n > mx) mx = n;
            es[2*b +: 2] = 2'((n > 3) ? 3 : n);
            el[b] = (n <= 3);
            chk("model_pulses", pulses[b] - base[b], (n > 3) ? 3 : n);
        end
        chk("model_done", done_o, mx <= 3);
        chk("model_fail", fail_o, mx > 3);
        chk("model_busy", busy_o, 1'b0);
        chk("model_slips", slips_o, es);
        chk("model_locked", locked_o, el);
        chk("model_calib", calib_o, '0);
    endtask

    initial begin
        int gaps[4] = '{3, 2, 3, 2};
        fork monitor(); join_none

        repeat (3) @(negedge clock);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_fail", fail_o, 1'b0);
        chk("rst_locked", locked_o, '0);
        chk("rst_slips", slips_o, '0);
        chk("rst_calib", calib_o, '0);
        chk("rst_valid_o", valid_o, 1'b0);
        chk("rst_data_o", data_o, '0);
        #1 reset_n = 1'b1;
        @(negedge clock);

        // both bits aligned from the start
        start_train();
        repeat (3) step(1'b1, 1'b0, 1'b0);
        chk("t1_done_early", done_o, 1'b0);
        chk("t1_busy", busy_o, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("t1_done", done_o, 1'b1);
        chk("t1_locked", locked_o, 2'b11);
        chk("t1_slips", slips_o, 4'b0000);
        check_model();

        // bit1 off by one position
        rot0[1] = 1;
        start_train();
        chk("t2_done_clear", done_o, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0);
        chk("t2_calib", calib_o, 2'b10);
        chk("t2_locked0", locked_o, 2'b01);
        step(1'b0, 1'b0, 1'b0);
        chk("t2_calib_off", calib_o, 2'b00);
        chk("t2_busy", busy_o, 1'b1);
        run_until(100, 1'b0);
        chk("t2_done", done_o, 1'b1);
        chk("t2_slips", slips_o, 4'b0100);
        check_model();

        // bit0 never matches
        rot0[1] = 0; never[0] = 1'b1; cval[0] = 4'b1111;
        start_train();
        run_until(100, 1'b0);
        chk("t3_fail", fail_o, 1'b1);
        chk("t3_slips0", slips_o[1:0], 2'b11);
        chk("t3_pulses0", pulses[0] - base[0], 3);
        check_model();
        never[0] = 1'b0;

        // sparse valid beats with zeroed idle data
        start_train();
        for (int i = 0; i < 4; i++) begin
            repeat (gaps[i]) step(1'b0, 1'b0, 1'b1);
            if (i == 3) begin
                chk("t4_done_early", done_o, 1'b0);
                chk("t4_busy", busy_o, 1'b1);
            end
            step(1'b1, 1'b0, 1'b1);
        end
        chk("t4_done", done_o, 1'b1);
        check_model();

        // reset during SLIP
        rot0[1] = 1;
        start_train();
        repeat (4) step(1'b1, 1'b0, 1'b0);
        chk("t5_calib", calib_o, 2'b10);
        #1 reset_n = 1'b0;
        #1;
        chk("t5_calib_cut", calib_o, '0);
        chk("t5_busy", busy_o, 1'b0);
        chk("t5_done", done_o, 1'b0);
        chk("t5_fail", fail_o, 1'b0);
        chk("t5_locked", locked_o, '0);
        chk("t5_slips", slips_o, '0);
        chk("t5_valid_o", valid_o, 1'b0);
        chk("t5_data_o", data_o, '0);
        @(negedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        rot0[1] = 2;
        start_train();
        chk("t5_restart_slips", slips_o, '0);
        chk("t5_restart_busy", busy_o, 1'b1);
        run_until(100, 1'b0);
        check_model();

        // start during CHECK does not restart the window
        rot0[1] = 1;
        start_train();
        repeat (2) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("t6_slips", slips_o, '0);
        chk("t6_locked", locked_o, '0);
        chk("t6_busy", busy_o, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("t6_calib", calib_o, 2'b10);
        run_until(100, 1'b0);
        chk("t6_slips_end", slips_o, 4'b0100);
        check_model();

        // randomized alignments, stuck bits, valid gaps and stray starts
        repeat (14) begin
            for (int b = 0; b < W; b++) begin
                rot0[b]  = $urandom_range(3);
                never[b] = ($urandom_range(3) == 0);
                do cval[b] = 4'($urandom);
                while (cval[b] == PAT || cval[b] == rotq(PAT, 1) ||
                       cval[b] == rotq(PAT, 2) || cval[b] == rotq(PAT, 3));
            end
            start_train();
            run_until(60, 1'b1);
            check_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
